// File: rtl/sim_halt_monitor_pkg.sv
// Shared CPU package for the simulation halt monitor: FSM state and halt-cause
// encodings plus a width helper for the internal counters.
package sim_halt_monitor_pkg;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    CAUSE_NONE          = 3'd0,
    CAUSE_TRAP          = 3'd1,
    CAUSE_HOST          = 3'd2,
    CAUSE_WATCHDOG      = 3'd3,
    CAUSE_DRAIN_TIMEOUT = 3'd4
  } halt_cause_t;

  // Bits needed to hold the value max_val (at least one bit).
  function automatic int cnt_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/sim_halt_monitor_sat_counter.sv
// Saturating up-counter with synchronous clear and count enable.
// Clear takes priority over enable; the count sticks at all-ones.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         en,
  output logic [W-1:0] count
);

  // Count up when enabled, hold at the top value instead of wrapping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (en && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/sim_halt_monitor.sv
// Simulation halt monitor: watches the pipeline for a trap or a host exit
// request, lets the older instructions drain, then raises a sticky halt with
// its cause. A watchdog and a drain timeout guarantee the run always ends.
module sim_halt_monitor
  import sim_halt_monitor_pkg::*;
#(
  parameter int NSTAGES   = 4,
  parameter int CNT_W     = 32,
  parameter int WDOG      = 100000,
  parameter int DRAIN_MAX = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NSTAGES-1:0] stage_valid,
  input  logic               trap_req,
  input  logic               retire,
  input  logic               host_wr,
  input  logic [31:0]        host_data,
  output logic               halt,
  output logic [2:0]         halt_cause,
  output logic [31:0]        exit_code,
  output logic [CNT_W-1:0]   cycle_cnt,
  output logic [CNT_W-1:0]   retire_cnt,
  output logic               draining
);

  localparam int WD_W = cnt_width(WDOG);
  localparam int DR_W = cnt_width(DRAIN_MAX);
  localparam logic [WD_W-1:0] WD_LAST = (WDOG == 0) ? '0 : WD_W'(WDOG - 1);
  localparam logic [DR_W-1:0] DR_LAST = DR_W'(DRAIN_MAX - 1);

  state_t      state, state_next;
  halt_cause_t pending_cause, cause_q, cause_at_halt;
  logic [31:0] exit_q;
  logic [WD_W-1:0] wd_cnt;
  logic [DR_W-1:0] drain_cnt;

  logic active, trap_fire, drained, wd_trip, drain_timeout, accept_req;

  assign active        = (state != ST_HALTED);
  assign trap_fire     = trap_req & stage_valid[0];
  assign drained       = ~|stage_valid[NSTAGES-1:1];
  // Trip on the edge where the idle count would reach WDOG.
  assign wd_trip       = (WDOG != 0) && active && !retire && (wd_cnt == WD_LAST);
  // Trip on the edge that completes the DRAIN_MAX-th drain cycle.
  assign drain_timeout = (state == ST_DRAIN) && (drain_cnt == DR_LAST);
  assign accept_req    = (state == ST_RUN) && !wd_trip && (host_wr | trap_fire);

  sat_counter #(.W(CNT_W)) u_cycle_cnt (
    .clk   (clk),
    .reset (reset),
    .clear (1'b0),
    .en    (active),
    .count (cycle_cnt)
  );

  sat_counter #(.W(CNT_W)) u_retire_cnt (
    .clk   (clk),
    .reset (reset),
    .clear (1'b0),
    .en    (active & retire),
    .count (retire_cnt)
  );

  sat_counter #(.W(WD_W)) u_wd_cnt (
    .clk   (clk),
    .reset (reset),
    .clear (active & retire),
    .en    (active),
    .count (wd_cnt)
  );

  sat_counter #(.W(DR_W)) u_drain_cnt (
    .clk   (clk),
    .reset (reset),
    .clear (state != ST_DRAIN),
    .en    (state == ST_DRAIN),
    .count (drain_cnt)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_RUN;
    end else begin
      state <= state_next;
    end
  end

  // Next state and the cause to record on entry to HALTED, in priority order.
  always_comb begin
    state_next    = state;
    cause_at_halt = pending_cause;
    unique case (state)
      ST_RUN: begin
        if (wd_trip) begin
          state_next    = ST_HALTED;
          cause_at_halt = CAUSE_WATCHDOG;
        end else if (host_wr || trap_fire) begin
          state_next = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (wd_trip) begin
          state_next    = ST_HALTED;
          cause_at_halt = CAUSE_WATCHDOG;
        end else if (drain_timeout) begin
          state_next    = ST_HALTED;
          cause_at_halt = CAUSE_DRAIN_TIMEOUT;
        end else if (drained) begin
          state_next = ST_HALTED;
        end
      end
      default: state_next = ST_HALTED;
    endcase
  end

  // Status outputs decoded from the state register.
  always_comb begin
    halt       = (state == ST_HALTED);
    draining   = (state == ST_DRAIN);
    halt_cause = cause_q;
    exit_code  = exit_q;
  end

  // Latch the first accepted request and the final cause; later requests are ignored.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending_cause <= CAUSE_NONE;
      cause_q       <= CAUSE_NONE;
      exit_q        <= '0;
    end else begin
      if (accept_req) begin
        pending_cause <= host_wr ? CAUSE_HOST : CAUSE_TRAP;
        if (host_wr) begin
          exit_q <= host_data;
        end
      end
      if (active && (state_next == ST_HALTED)) begin
        cause_q <= cause_at_halt;
      end
    end
  end

endmodule

// File: tb/tb_sim_halt_monitor.sv
// Scoreboard bench for sim_halt_monitor: directed scenarios push the expected
// halt record, and a monitor compares it when the DUT raises halt.
module tb_sim_halt_monitor;

  typedef struct {
    logic [2:0]  cause;
    logic [31:0] exit_code;
    int          cycles;
    int          retires;
  } exp_t;

  logic clk, reset;

  logic [3:0]  sv_a, sv_b;
  logic        trap_a, retire_a, host_wr_a;
  logic        trap_b, retire_b, host_wr_b;
  logic [31:0] host_data_a, host_data_b;
  logic        halt_a, draining_a, halt_b, draining_b;
  logic [2:0]  cause_a, cause_b;
  logic [31:0] exit_a, exit_b;
  logic [7:0]  cycle_a, rcnt_a;
  logic [3:0]  cycle_b, rcnt_b;

  int checks, failures;
  exp_t exp_a[$];
  exp_t exp_b[$];
  exp_t e_a, e_b;
  logic halt_a_prev, halt_b_prev;

  sim_halt_monitor #(.NSTAGES(4), .CNT_W(8), .WDOG(50), .DRAIN_MAX(4)) dut_a (
    .clk(clk), .reset(reset), .stage_valid(sv_a), .trap_req(trap_a),
    .retire(retire_a), .host_wr(host_wr_a), .host_data(host_data_a),
    .halt(halt_a), .halt_cause(cause_a), .exit_code(exit_a),
    .cycle_cnt(cycle_a), .retire_cnt(rcnt_a), .draining(draining_a)
  );

  sim_halt_monitor #(.NSTAGES(4), .CNT_W(4), .WDOG(0), .DRAIN_MAX(16)) dut_b (
    .clk(clk), .reset(reset), .stage_valid(sv_b), .trap_req(trap_b),
    .retire(retire_b), .host_wr(host_wr_b), .host_data(host_data_b),
    .halt(halt_b), .halt_cause(cause_b), .exit_code(exit_b),
    .cycle_cnt(cycle_b), .retire_cnt(rcnt_b), .draining(draining_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input longint unsigned actual,
                             input longint unsigned expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] sv, input logic trap, input logic ret,
                               input logic hw, input logic [31:0] hd);
    sv_a = sv; trap_a = trap; retire_a = ret; host_wr_a = hw; host_data_a = hd;
    @(negedge clk);
  endtask

  task automatic stimB(input logic ret, input logic hw, input logic [31:0] hd);
    retire_b = ret; host_wr_b = hw; host_data_b = hd;
    @(negedge clk);
  endtask

  task automatic pushA(input logic [2:0] c, input logic [31:0] x, input int cy, input int rt);
    exp_t e;
    e.cause = c; e.exit_code = x; e.cycles = cy; e.retires = rt;
    exp_a.push_back(e);
  endtask

  task automatic pushB(input logic [2:0] c, input logic [31:0] x, input int cy, input int rt);
    exp_t e;
    e.cause = c; e.exit_code = x; e.cycles = cy; e.retires = rt;
    exp_b.push_back(e);
  endtask

  task automatic doReset();
    reset = 1'b1;
    sv_a = '0; trap_a = 0; retire_a = 0; host_wr_a = 0; host_data_a = '0;
    sv_b = '0; trap_b = 0; retire_b = 0; host_wr_b = 0; host_data_b = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic checkIdleA(input string tag);
    checkOutput({tag, "_a_halt"}, halt_a, 0);
    checkOutput({tag, "_a_cause"}, cause_a, 0);
    checkOutput({tag, "_a_exit"}, exit_a, 0);
    checkOutput({tag, "_a_cycle"}, cycle_a, 0);
    checkOutput({tag, "_a_retire"}, rcnt_a, 0);
    checkOutput({tag, "_a_draining"}, draining_a, 0);
  endtask

  task automatic checkIdleB(input string tag);
    checkOutput({tag, "_b_halt"}, halt_b, 0);
    checkOutput({tag, "_b_cause"}, cause_b, 0);
    checkOutput({tag, "_b_exit"}, exit_b, 0);
    checkOutput({tag, "_b_cycle"}, cycle_b, 0);
    checkOutput({tag, "_b_retire"}, rcnt_b, 0);
    checkOutput({tag, "_b_draining"}, draining_b, 0);
  endtask

  task automatic checkPending(input string tag);
    checkOutput({tag, "_pending_a"}, exp_a.size(), 0);
    checkOutput({tag, "_pending_b"}, exp_b.size(), 0);
    exp_a.delete();
    exp_b.delete();
  endtask

  // Monitor: compare the halt record against the scoreboard on each rising halt.
  always @(negedge clk) begin
    if (halt_a && !halt_a_prev) begin
      if (exp_a.size() == 0) begin
        checks++; failures++;
        $display("[TB] FAIL unexpected_halt_a: got cause %0d expected no halt", cause_a);
      end else begin
        e_a = exp_a.pop_front();
        checkOutput("mon_a_cause", cause_a, e_a.cause);
        checkOutput("mon_a_exit", exit_a, e_a.exit_code);
        checkOutput("mon_a_cycle", cycle_a, e_a.cycles);
        checkOutput("mon_a_retire", rcnt_a, e_a.retires);
      end
    end
    if (halt_b && !halt_b_prev) begin
      if (exp_b.size() == 0) begin
        checks++; failures++;
        $display("[TB] FAIL unexpected_halt_b: got cause %0d expected no halt", cause_b);
      end else begin
        e_b = exp_b.pop_front();
        checkOutput("mon_b_cause", cause_b, e_b.cause);
        checkOutput("mon_b_exit", exit_b, e_b.exit_code);
        checkOutput("mon_b_cycle", cycle_b, e_b.cycles);
        checkOutput("mon_b_retire", rcnt_b, e_b.retires);
      end
    end
    halt_a_prev = halt_a;
    halt_b_prev = halt_b;
  end

  initial begin
    checks = 0; failures = 0;
    halt_a_prev = 0; halt_b_prev = 0;

    // Trap drains over three cycles, decode slot ignored; frozen afterwards.
    doReset();
    checkIdleA("reset");
    checkIdleB("reset");
    pushA(3'd1, 32'h0, 4, 0);
    applyStimulus(4'b1111, 1, 0, 0, 32'h0);
    checkOutput("t1_draining", draining_a, 1);
    applyStimulus(4'b1100, 0, 0, 0, 32'h0);
    applyStimulus(4'b1000, 0, 0, 0, 32'h0);
    checkOutput("t1_not_yet_halted", halt_a, 0);
    applyStimulus(4'b0001, 0, 0, 0, 32'h0);
    checkOutput("t1_halt", halt_a, 1);
    repeat (3) applyStimulus(4'b0000, 0, 1, 1, 32'hDEAD);
    checkOutput("t1_frozen_cycle", cycle_a, 4);
    checkOutput("t1_frozen_retire", rcnt_a, 0);
    checkOutput("t1_cause_kept", cause_a, 1);
    checkOutput("t1_exit_kept", exit_a, 0);
    checkPending("t1");

    // Host exit with empty pipeline; retire in the halting cycle still counts.
    doReset();
    pushA(3'd2, 32'h2A, 2, 2);
    applyStimulus(4'b0000, 0, 1, 1, 32'h2A);
    applyStimulus(4'b0000, 0, 1, 0, 32'h0);
    repeat (2) applyStimulus(4'b0000, 0, 0, 0, 32'h0);
    checkPending("t2");

    // Watchdog with no retirement.
    doReset();
    pushA(3'd3, 32'h0, 50, 0);
    repeat (55) applyStimulus(4'b0000, 0, 0, 0, 32'h0);
    checkOutput("t3_cycle_frozen", cycle_a, 50);
    checkPending("t3");

    // Drain timeout with stage 2 stuck.
    doReset();
    pushA(3'd4, 32'h0, 5, 0);
    applyStimulus(4'b0101, 1, 0, 0, 32'h0);
    repeat (4) applyStimulus(4'b0100, 0, 0, 0, 32'h0);
    repeat (2) applyStimulus(4'b0000, 0, 0, 0, 32'h0);
    checkPending("t4");

    // Host beats trap; second host_wr during DRAIN ignored.
    doReset();
    pushA(3'd2, 32'h11, 3, 0);
    applyStimulus(4'b0011, 1, 0, 1, 32'h11);
    applyStimulus(4'b0010, 0, 0, 1, 32'h99);
    applyStimulus(4'b0000, 0, 0, 0, 32'h0);
    repeat (2) applyStimulus(4'b0000, 0, 0, 0, 32'h0);
    checkOutput("t5_exit", exit_a, 32'h11);
    checkPending("t5");

    // Watchdog wins over a drain completing in the same cycle.
    doReset();
    pushA(3'd3, 32'h5, 50, 0);
    repeat (48) applyStimulus(4'b0000, 0, 0, 0, 32'h0);
    applyStimulus(4'b0000, 0, 0, 1, 32'h5);
    applyStimulus(4'b0000, 0, 0, 0, 32'h0);
    repeat (2) applyStimulus(4'b0000, 0, 0, 0, 32'h0);
    checkPending("t6");

    // Asynchronous reset in the middle of DRAIN.
    doReset();
    applyStimulus(4'b0110, 0, 0, 1, 32'hAB);
    applyStimulus(4'b0110, 0, 0, 0, 32'h0);
    checkOutput("t8_draining", draining_a, 1);
    #2 reset = 1'b1;
    #1 checkIdleA("t8_async");
    @(negedge clk);
    reset = 1'b0;
    repeat (3) applyStimulus(4'b0000, 0, 0, 0, 32'h0);
    checkOutput("t8_cycle_resumed", cycle_a, 3);
    checkPending("t8");

    // Narrow counters saturate; reset in HALTED clears and counting resumes.
    doReset();
    pushB(3'd2, 32'h7, 15, 15);
    repeat (20) stimB(1, 0, 32'h0);
    stimB(0, 1, 32'h7);
    stimB(0, 0, 32'h0);
    checkOutput("t7_b_halt", halt_b, 1);
    #2 reset = 1'b1;
    #1 checkIdleB("t7_async");
    @(negedge clk);
    reset = 1'b0;
    repeat (3) stimB(1, 0, 32'h0);
    retire_b = 0;
    checkOutput("t7_b_retire_resumed", rcnt_b, 3);
    checkOutput("t7_b_cycle_resumed", cycle_b, 3);
    checkOutput("t7_b_halt_after", halt_b, 0);
    checkPending("t7");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sim_halt_monitor.md
SIM_HALT_MONITOR -- requirements
Module: sim_halt_monitor

Interface
REQ-001 SHALL have parameter NSTAGES, default 4, number of pipeline stages monitored (index 0 = decode, NSTAGES-1 = writeback); legal range 2..8.
REQ-002 SHALL have parameter CNT_W, default 32, width of cycle and retire counters.
REQ-003 SHALL have parameter WDOG, default 100000, number of cycles without retirement before watchdog halt; 0 disables the watchdog.
REQ-004 SHALL have parameter DRAIN_MAX, default 16, maximum number of DRAIN cycles before forced halt.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 stage_valid  input  NSTAGES  per-stage valid flags.
REQ-008 trap_req  input  1  decode-stage error (illegal instruction); meaningful only when stage_valid[0]=1.
REQ-009 retire  input  1  one-cycle pulse per retired instruction.
REQ-010 host_wr  input  1  program exit request (tohost-style write).
REQ-011 host_data  input  32  exit value accompanying host_wr.
REQ-012 halt  output  1  registered, sticky halt indication.
REQ-013 halt_cause  output  3  0 NONE, 1 TRAP, 2 HOST, 3 WATCHDOG, 4 DRAIN_TIMEOUT.
REQ-014 exit_code  output  32  host_data captured on the accepted host_wr; 0 otherwise.
REQ-015 cycle_cnt  output  CNT_W  cycles since reset release, frozen at halt.
REQ-016 retire_cnt  output  CNT_W  retire pulses counted since reset, frozen at halt.
REQ-017 draining  output  1  high while in DRAIN.

Function
REQ-018 SHALL implement FSM states RUN, DRAIN, HALTED; RUN after reset.
REQ-019 RUN->DRAIN SHALL occur when (trap_req & stage_valid[0]) or host_wr; pending cause latched (HOST beats TRAP if both occur in the same cycle; exit_code latched only for HOST).
REQ-020 DRAIN->HALTED SHALL occur in the first cycle in which stage_valid[NSTAGES-1:1]==0; halt and halt_cause become visible on the following rising edge (1-cycle latency).
REQ-021 Draining SHALL ignore stage_valid[0] (the faulting/younger decode slot never drains).
REQ-022 DRAIN SHALL force HALTED with cause DRAIN_TIMEOUT when the DRAIN cycle count reaches DRAIN_MAX without a drained pipeline.
REQ-023 Watchdog counter SHALL reset to 0 on each retire and increment otherwise in RUN and DRAIN; on reaching WDOG (WDOG!=0) the FSM SHALL go directly to HALTED with cause WATCHDOG.
REQ-024 Same-cycle priority SHALL be WATCHDOG > DRAIN_TIMEOUT > drain complete > new HOST/TRAP request.
REQ-025 In DRAIN or HALTED, further host_wr/trap_req SHALL be ignored (cause and exit_code keep first value).
REQ-026 HALTED SHALL be absorbing until reset; counters frozen; retire ignored.
REQ-027 cycle_cnt and retire_cnt SHALL saturate at all-ones, not wrap.
REQ-028 retire in the cycle of the transition to HALTED SHALL still be counted.

Reset
REQ-029 On reset: state RUN, halt=0, halt_cause=0, exit_code=0, cycle_cnt=0, retire_cnt=0, draining=0, watchdog and drain counters 0.
REQ-030 Reset asserted mid-DRAIN or in HALTED SHALL return all state to the REQ-029 values immediately (asynchronously).

Structure
REQ-031 Halt-cause encodings and FSM state encodings SHALL reside in the shared CPU package.
REQ-032 A sub-module sat_counter (parameterised width, enable, clear, saturating) SHALL be used for cycle, retire, watchdog and drain counters.

Verification
REQ-033 NSTAGES=4: trap_req with stage_valid=4'b1111, stages 1..3 clear over 3 cycles -> halt=1 one cycle after stage_valid[3:1]==0, cause=1.
REQ-034 host_wr, host_data=0x0000002A, pipeline empty -> halt after 2 edges, cause=2, exit_code=0x2A.
REQ-035 WDOG=50, no retire -> halt at cycle 51, cause=3, cycle_cnt=50.
REQ-036 DRAIN_MAX=4, stage_valid[2] held high after trap -> cause=4 after 4 DRAIN cycles.
REQ-037 host_wr and trap_req in the same cycle -> cause=2; a second host_wr during DRAIN -> exit_code unchanged.
REQ-038 CNT_W=4, 20 retires -> retire_cnt=15; reset pulse in HALTED -> all outputs 0, counting resumes.
